// File: rtl/snes_pkg.sv
// snes_pkg
//   Shared definitions for the SNES controller port logic (reader and encoder).
//   Holds the transaction state enum, the button bit positions inside the
//   16-bit button word, the default shift length and a small helper function.
package snes_pkg;

  // Transaction phases of one pad read.
  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_LO,
    CLK_HI,
    DONE
  } snes_state_e;

  // Bit positions in the button word (1 = pressed); bits 12..15 are reserved.
  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  // Number of bits clocked out of a standard pad per read.
  localparam int SNES_NUM_BITS = 16;

  // Larger of two integers, used to size shared counters.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/snes_sync2.sv
// snes_sync2
//   Two-flop synchronizer for the asynchronous pad data line.
//   Resets to 1 because an idle / released line reads high.
// Ports
//   clk    in  system clock
//   reset  in  asynchronous active-high reset
//   d      in  asynchronous input
//   q      out synchronized output
module snes_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/snes_reader.sv
// snes_reader
//   Console-side SNES controller port master. Pulses the latch, clocks out
//   NUM_BITS serial bits from the pad and publishes a 16-bit active-high
//   button word. A read starts on a free-running poll timer wrap or on
//   poll_req, but only while idle; requests arriving while busy are dropped.
//   Optional macro: SNES_READER_PRESENT_EN enables pad detection from the
//   reserved bits; without it present is 1 whenever reset is released.
// Ports
//   clk           in   system clock
//   reset         in   asynchronous active-high reset
//   poll_req      in   one-cycle request to read now
//   snes_data_in  in   serial pad data, active-low, asynchronous
//   snes_latch    out  latch to pad, active-high
//   snes_clk      out  serial clock to pad, idles high
//   buttons       out  last completed read, 1 = pressed
//   valid         out  one-cycle pulse when buttons updates
//   busy          out  high from transaction start through DONE
//   present       out  pad detected
module snes_reader
  import snes_pkg::*;
#(
  parameter int LATCH_CYC = 25,
  parameter int HALF_CYC  = 12,
  parameter int POLL_CYC  = 34667,
  parameter int NUM_BITS  = SNES_NUM_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        poll_req,
  input  logic        snes_data_in,
  output logic        snes_latch,
  output logic        snes_clk,
  output logic [15:0] buttons,
  output logic        valid,
  output logic        busy,
  output logic        present
);

  localparam int PHASE_MAX = max_int(LATCH_CYC, HALF_CYC);
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam int POLL_W    = $clog2(POLL_CYC + 1);

  snes_state_e        state_q,   state_d;
  logic [PHASE_W-1:0] phase_q,   phase_d;
  logic [3:0]         bit_idx_q, bit_idx_d;
  logic [15:0]        shift_q,   shift_d;
  logic [POLL_W-1:0]  poll_q,    poll_d;
  logic [15:0]        buttons_q, buttons_d;
  logic               present_q, present_d;
  logic               latch_q,   latch_d;
  logic               sclk_q,    sclk_d;
  logic               busy_q,    busy_d;
  logic               valid_q,   valid_d;

  logic data_sync;
  logic poll_wrap;

  snes_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (snes_data_in),
    .q     (data_sync)
  );

  assign poll_wrap = (poll_q == POLL_W'(POLL_CYC - 1));

  // Next-state logic. The pad outputs are registered from the next state so
  // they line up exactly with state_q and cannot glitch.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    poll_d    = poll_wrap ? '0 : poll_q + POLL_W'(1);
    buttons_d = buttons_q;
    present_d = present_q;

    unique case (state_q)
      IDLE: begin
        if (poll_req || poll_wrap) begin
          state_d   = LATCH;
          phase_d   = '0;
          bit_idx_d = '0;
          shift_d   = '0;
        end
      end
      LATCH: begin
        if (phase_q == PHASE_W'(LATCH_CYC - 1)) begin
          state_d = CLK_LO;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end
      CLK_LO: begin
        // Sample as late as possible in the low phase; the pad line is
        // active-low, so invert to get 1 = pressed.
        if (phase_q == PHASE_W'(HALF_CYC - 1)) begin
          shift_d[bit_idx_q] = ~data_sync;
          state_d            = CLK_HI;
          phase_d            = '0;
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end
      CLK_HI: begin
        if (phase_q == PHASE_W'(HALF_CYC - 1)) begin
          phase_d = '0;
          if (bit_idx_q == 4'(NUM_BITS - 1)) begin
            state_d = DONE;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            state_d   = CLK_LO;
          end
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    latch_d = (state_d == LATCH);
    sclk_d  = (state_d != CLK_LO);
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);

`ifdef SNES_READER_PRESENT_EN
    // A genuine pad reports its reserved bits as released; anything else is
    // treated as no pad and the word is suppressed.
    if (state_d == DONE) begin
      present_d = (shift_q[15:12] == 4'b0000);
      buttons_d = (shift_q[15:12] == 4'b0000) ? shift_q : 16'h0000;
    end
`else
    present_d = 1'b1;
    if (state_d == DONE) begin
      buttons_d = shift_q;
    end
`endif
  end

  // State and output registers; reset abandons any read in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      poll_q    <= '0;
      buttons_q <= '0;
      present_q <= 1'b0;
      latch_q   <= 1'b0;
      sclk_q    <= 1'b1;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      poll_q    <= poll_d;
      buttons_q <= buttons_d;
      present_q <= present_d;
      latch_q   <= latch_d;
      sclk_q    <= sclk_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign snes_latch = latch_q;
  assign snes_clk   = sclk_q;
  assign buttons    = buttons_q;
  assign valid      = valid_q;
  assign busy       = busy_q;
  assign present    = present_q;

endmodule

// File: tb/tb_snes_reader.sv
// tb_snes_reader
//   Directed bench for snes_reader with a behavioural SNES pad. Each read the
//   bench launches pushes its expected {present, buttons} onto a queue; a
//   monitor pops and compares on every valid pulse.
module tb_snes_reader;

  localparam int LATCH_CYC = 4;
  localparam int HALF_CYC  = 3;
  localparam int POLL_CYC  = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        poll_req;
  logic        snes_data_in;
  logic        snes_latch;
  logic        snes_clk;
  logic [15:0] buttons;
  logic        valid;
  logic        busy;
  logic        present;

  logic [15:0] pad_word;
  logic        pad_hold0;
  int          pad_idx = 0;

  int          tests  = 0;
  int          fails  = 0;
  int          vcount = 0;
  logic [16:0] exp_q[$];
  logic [16:0] sb_exp;

  int   lat_cnt, falls, vidx, vwidth, starts, last, v0, n;
  logic prev_sclk, prev_busy, found;

  snes_reader #(
    .LATCH_CYC (LATCH_CYC),
    .HALF_CYC  (HALF_CYC),
    .POLL_CYC  (POLL_CYC),
    .NUM_BITS  (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .poll_req     (poll_req),
    .snes_data_in (snes_data_in),
    .snes_latch   (snes_latch),
    .snes_clk     (snes_clk),
    .buttons      (buttons),
    .valid        (valid),
    .busy         (busy),
    .present      (present)
  );

  always #5 clk = ~clk;

  // Pad model: latch reloads, each rising serial clock advances one bit.
  always @(posedge snes_latch or posedge snes_clk) begin
    if (snes_latch) pad_idx <= 0;
    else            pad_idx <= pad_idx + 1;
  end

  assign snes_data_in = pad_hold0 ? 1'b0 :
                        ((pad_idx < 16) ? ~pad_word[pad_idx[3:0]] : 1'b0);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] expectFor(input logic [15:0] word);
`ifdef SNES_READER_PRESENT_EN
    if (word[15:12] == 4'b0000) return {1'b1, word};
    else                        return {1'b0, 16'h0000};
`else
    return {1'b1, word};
`endif
  endfunction

  // Sets the pad contents and pulses poll_req for one cycle; optionally
  // records the word the read should deliver.
  task automatic applyStimulus(input logic [15:0] word, input logic hold0, input logic push);
    pad_word  = word;
    pad_hold0 = hold0;
    poll_req  = 1'b1;
    if (push) exp_q.push_back(expectFor(hold0 ? 16'hFFFF : word));
    @(negedge clk);
    poll_req = 1'b0;
  endtask

  task automatic waitValid(input int limit, output int idx);
    idx = -1;
    for (int i = 1; i <= limit; i++) begin
      if (valid === 1'b1) begin
        idx = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest pending read.
  always @(negedge clk) begin
    if (reset === 1'b0 && valid === 1'b1) begin
      vcount++;
      checkOutput("sb_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        sb_exp = exp_q.pop_front();
        checkOutput("sb_buttons", buttons, sb_exp[15:0]);
        checkOutput("sb_present", present, sb_exp[16]);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset     = 1'b1;
    poll_req  = 1'b0;
    pad_word  = 16'h0000;
    pad_hold0 = 1'b0;
    repeat (3) @(negedge clk);

    // 1: reset values
    checkOutput("rst_latch",   snes_latch, 0);
    checkOutput("rst_sclk",    snes_clk,   1);
    checkOutput("rst_buttons", buttons,    0);
    checkOutput("rst_valid",   valid,      0);
    checkOutput("rst_busy",    busy,       0);
    checkOutput("rst_present", present,    0);

    // 2: requested read of B+Start, timing of latch/clock/valid
    reset = 1'b0;
    applyStimulus(16'h0009, 1'b0, 1'b1);
    checkOutput("t2_busy_start", busy, 1);
    lat_cnt = 0; falls = 0; vidx = -1; vwidth = 0; prev_sclk = 1'b1;
    for (int i = 1; i <= 150; i++) begin
      if (snes_latch) lat_cnt++;
      if (prev_sclk && !snes_clk) falls++;
      prev_sclk = snes_clk;
      if (valid) begin
        vwidth++;
        if (vidx < 0) vidx = i;
      end
      @(negedge clk);
    end
    checkOutput("t2_latch_cycles", lat_cnt, 4);
    checkOutput("t2_clk_falls",    falls,   16);
    checkOutput("t2_valid_cycle",  vidx,    101);
    checkOutput("t2_valid_width",  vwidth,  1);
    checkOutput("t2_buttons",      buttons, 16'h0009);
    checkOutput("t2_present",      present, 1);
    checkOutput("t2_busy_end",     busy,    0);

    // 3: auto-poll only, 1000 cycles from the first timer start
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    pad_word = 16'h0A50;
    for (int k = 0; k < 5; k++) exp_q.push_back(expectFor(16'h0A50));
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("t3_first_start", found, 1);
    v0 = vcount; starts = 1; last = 0; prev_busy = 1'b1;
    for (int i = 1; i < 1000; i++) begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        starts++;
        checkOutput("t3_interval", i - last, 200);
        last = i;
      end
      prev_busy = busy;
    end
    checkOutput("t3_starts",  starts,        5);
    checkOutput("t3_valids",  vcount - v0,   5);
    checkOutput("t3_drained", exp_q.size(),  0);

    // 4: poll_req during bit 5 is dropped
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    v0 = vcount;
    applyStimulus(16'h0C3A, 1'b0, 1'b1);
    repeat (35) @(negedge clk);
    checkOutput("t4_in_bit5_low", snes_clk, 0);
    checkOutput("t4_busy",        busy,     1);
    applyStimulus(16'h0C3A, 1'b0, 1'b0);
    repeat (120) @(negedge clk);
    checkOutput("t4_one_valid", vcount - v0,  1);
    checkOutput("t4_buttons",   buttons,      16'h0C3A);
    checkOutput("t4_drained",   exp_q.size(), 0);

    // 5: reset during bit 7 low phase, then a clean re-read
    applyStimulus(16'h0123, 1'b0, 1'b1);
    repeat (47) @(negedge clk);
    checkOutput("t5_in_bit7_low", snes_clk, 0);
    checkOutput("t5_old_word",    buttons,  16'h0C3A);
    reset = 1'b1;
    #1;
    checkOutput("t5_rst_latch",   snes_latch, 0);
    checkOutput("t5_rst_sclk",    snes_clk,   1);
    checkOutput("t5_rst_busy",    busy,       0);
    checkOutput("t5_rst_buttons", buttons,    0);
    checkOutput("t5_rst_present", present,    0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    applyStimulus(16'h0123, 1'b0, 1'b1);
    waitValid(150, n);
    checkOutput("t5_reread_latency", n, 101);
    @(negedge clk);
    checkOutput("t5_buttons", buttons, 16'h0123);

    // 6: data pin stuck low
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    applyStimulus(16'h0000, 1'b1, 1'b1);
    waitValid(150, n);
    checkOutput("t6_valid_seen", 32'(n > 0), 1);
    @(negedge clk);
`ifdef SNES_READER_PRESENT_EN
    checkOutput("t6_present", present, 0);
    checkOutput("t6_buttons", buttons, 16'h0000);
`else
    checkOutput("t6_present", present, 1);
    checkOutput("t6_buttons", buttons, 16'hFFFF);
`endif
    checkOutput("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
